// File: rtl/cpu_ctrl_pkg.sv
// Shared types and constants for the multi-cycle CPU control sequencer.
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT
  } state_e;

  localparam logic [3:0] OP_ADD   = 4'h0;
  localparam logic [3:0] OP_SUB   = 4'h1;
  localparam logic [3:0] OP_AND   = 4'h2;
  localparam logic [3:0] OP_OR    = 4'h3;
  localparam logic [3:0] OP_XOR   = 4'h4;
  localparam logic [3:0] OP_LOAD  = 4'h5;
  localparam logic [3:0] OP_STORE = 4'h6;
  localparam logic [3:0] OP_HALT  = 4'hF;

  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 8;
  localparam int RS1_MSB = 7;
  localparam int RS1_LSB = 4;
  localparam int RS2_MSB = 3;
  localparam int RS2_LSB = 0;

endpackage

// File: rtl/cpu_op_decode.sv
// Opcode classifier, shared by the sequencer and the operand-select/ALU logic.
module cpu_op_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [3:0] op_i,
  output logic       is_alu_o,
  output logic       is_load_o,
  output logic       is_store_o,
  output logic       is_halt_o,
  output logic       is_illegal_o
);

  always_comb begin
    is_alu_o     = (op_i <= OP_XOR);
    is_load_o    = (op_i == OP_LOAD);
    is_store_o   = (op_i == OP_STORE);
    is_halt_o    = (op_i == OP_HALT);
    is_illegal_o = !(is_alu_o || is_load_o || is_store_o || is_halt_o);
  end

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle fetch/decode/exec/mem/wb sequencer for the 16-bit CPU.
// Define CPU_CTRL_ILLEGAL_TRAP_EN to make illegal opcodes set a sticky trap and halt.
module cpu_ctrl_fsm
  import cpu_ctrl_pkg::*;
#(
  parameter int N  = 16,
  parameter int AW = 8,
  parameter logic [AW-1:0] RST_PC = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [N-1:0]  mem_wdata,
  input  logic          mem_ack,
  input  logic [N-1:0]  mem_rdata,
  output logic [3:0]    op_code,
  output logic [3:0]    rf_raddr1,
  output logic [3:0]    rf_raddr2,
  input  logic [N-1:0]  rs2_data,
  input  logic [N-1:0]  alu_res,
  output logic          rf_we,
  output logic [3:0]    rf_waddr,
  output logic [N-1:0]  rf_wdata,
  output logic [AW-1:0] pc,
  output logic          busy,
  output logic          halted,
  output logic          trap
);

`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
  localparam state_e ILL_NEXT = HALT;
`else
  localparam state_e ILL_NEXT = FETCH;
`endif

  state_e        state_q, state_d;
  logic [AW-1:0] pc_q;
  logic [N-1:0]  ir_q;
  logic [AW-1:0] addr_q;
  logic [N-1:0]  wdata_q;
  logic [N-1:0]  rfwd_q;
  logic          is_alu, is_load, is_store, is_halt, is_illegal;

  cpu_op_decode u_dec (
    .op_i         (ir_q[OP_MSB:OP_LSB]),
    .is_alu_o     (is_alu),
    .is_load_o    (is_load),
    .is_store_o   (is_store),
    .is_halt_o    (is_halt),
    .is_illegal_o (is_illegal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (start) state_d = FETCH;
      FETCH:  if (mem_ack) state_d = DECODE;
      DECODE: begin
        if (is_halt)         state_d = HALT;
        else if (is_illegal) state_d = ILL_NEXT;
        else                 state_d = EXEC;
      end
      EXEC:   state_d = is_alu ? WB : MEM;
      MEM:    if (mem_ack) state_d = is_load ? WB : FETCH;
      WB:     state_d = FETCH;
      HALT:   if (start) state_d = FETCH;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    mem_addr = addr_q;
    rf_we    = 1'b0;
    busy     = 1'b1;
    halted   = 1'b0;
    case (state_q)
      IDLE:  busy = 1'b0;
      FETCH: begin
        mem_req  = 1'b1;
        mem_addr = pc_q;
      end
      MEM: begin
        mem_req = 1'b1;
        mem_we  = is_store;
      end
      WB:    rf_we = 1'b1;
      HALT: begin
        busy   = 1'b0;
        halted = 1'b1;
      end
      default: ;
    endcase
  end

  // Address and store data are captured in EXEC so they stay stable across MEM waits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RST_PC;
      ir_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rfwd_q  <= '0;
    end else begin
      if (state_q == FETCH && mem_ack) begin
        ir_q <= mem_rdata;
        pc_q <= pc_q + AW'(1);
      end
      if (state_q == EXEC) begin
        if (is_alu) begin
          rfwd_q <= alu_res;
        end else begin
          addr_q  <= rs2_data[AW-1:0];
          wdata_q <= rs2_data;
        end
      end
      if (state_q == MEM && mem_ack && is_load) rfwd_q <= mem_rdata;
    end
  end

`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
  logic trap_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              trap_q <= 1'b0;
    else if (state_q == DECODE && is_illegal) trap_q <= 1'b1;
  end
  assign trap = trap_q;
`else
  assign trap = 1'b0;
`endif

  assign op_code   = ir_q[OP_MSB:OP_LSB];
  assign rf_waddr  = ir_q[RD_MSB:RD_LSB];
  assign rf_raddr1 = ir_q[RS1_MSB:RS1_LSB];
  assign rf_raddr2 = ir_q[RS2_MSB:RS2_LSB];
  assign mem_wdata = wdata_q;
  assign rf_wdata  = rfwd_q;
  assign pc        = pc_q;

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Random-program bench: an instruction-level model expands each instruction into its
// expected per-cycle trace from the latency rules; one process compares every cycle.
module tb_cpu_ctrl_fsm;
  localparam int N  = 16;
  localparam int AW = 8;
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0, mem_ack = 1'b0;
  logic [N-1:0]  mem_rdata = '0, alu_res = '0, rs2_data;
  logic          mem_req, mem_we, rf_we, busy, halted, trap;
  logic [AW-1:0] mem_addr, pc;
  logic [N-1:0]  mem_wdata, rf_wdata;
  logic [3:0]    op_code, rf_raddr1, rf_raddr2, rf_waddr;

  logic [N-1:0] regs [16];
  logic [N-1:0] pmem [256];

  cpu_ctrl_fsm #(.N(N), .AW(AW), .RST_PC(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .op_code(op_code), .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rs2_data(rs2_data),
    .alu_res(alu_res), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .pc(pc), .busy(busy), .halted(halted), .trap(trap)
  );

  assign rs2_data = regs[rf_raddr2];
  always #5 clk = ~clk;

  typedef struct {
    bit          start, ack;
    logic [15:0] rdata, alu;
    bit          req, we, rfwe, busy, halted, trap;
    logic [7:0]  addr, pc;
    logic [15:0] wdata, rfwdata, ir;
  } cyc_t;

  cyc_t        tr[$];
  cyc_t        e;
  int          cur = -1;
  bit          run = 1'b0;
  int          n_chk = 0, n_pass = 0;
  logic [7:0]  m_pc;
  logic [15:0] m_ir;
  bit          m_trap;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cyc=%0d t=%0t got=%h want=%h", nm, cur, $time, act, exp);
  endtask

  // Default cycle: idle-side outputs, random noise on start/ack that the DUT must ignore.
  function automatic cyc_t base();
    cyc_t c;
    c.start = ($urandom_range(0, 4) == 0);
    c.ack   = ($urandom_range(0, 2) == 0);
    c.rdata = 16'($urandom);
    c.alu   = 16'($urandom);
    c.req = 1'b0; c.we = 1'b0; c.rfwe = 1'b0;
    c.busy = 1'b1; c.halted = 1'b0; c.trap = m_trap;
    c.addr = '0; c.wdata = '0; c.rfwdata = '0;
    c.pc = m_pc; c.ir = m_ir;
    return c;
  endfunction

  task automatic gen();
    cyc_t        c;
    logic [15:0] ins, rv, v;
    logic [3:0]  op;
    int          fw, dw, wl, hn;
    m_pc = 8'h00; m_ir = '0; m_trap = 1'b0;
    c = base(); c.start = 1'b1; c.busy = 1'b0; tr.push_back(c);
    for (int k = 0; k <= 300; k++) begin
      ins = (k == 300) ? 16'h5304 : pmem[m_pc];
      fw  = (k < 5) ? 0 : $urandom_range(0, 2);
      for (int w = 0; w <= fw; w++) begin
        c = base(); c.req = 1'b1; c.addr = m_pc; c.ack = (w == fw);
        if (w == fw) c.rdata = ins;
        tr.push_back(c);
      end
      m_pc = m_pc + 8'd1;
      m_ir = ins;
      op = ins[15:12];
      rv = regs[ins[3:0]];
      tr.push_back(base());
      if (op <= 4'd4) begin
        c = base(); v = c.alu; tr.push_back(c);
        c = base(); c.rfwe = 1'b1; c.rfwdata = v; tr.push_back(c);
      end else if (op == 4'd5 || op == 4'd6) begin
        tr.push_back(base());
        dw = (k == 1) ? 3 : (k == 2) ? 0 : (k == 300) ? 9 : $urandom_range(0, 3);
        wl = (k == 300) ? 1 : dw;
        v  = (k == 1) ? 16'hBEEF : 16'($urandom);
        for (int w = 0; w <= wl; w++) begin
          c = base(); c.req = 1'b1; c.we = (op == 4'd6); c.addr = rv[7:0]; c.wdata = rv;
          c.ack = (w == dw);
          if (w == dw) c.rdata = v;
          tr.push_back(c);
        end
        if (op == 4'd5 && k != 300) begin
          c = base(); c.rfwe = 1'b1; c.rfwdata = v; tr.push_back(c);
        end
      end else if (op == 4'hF || TRAP_EN) begin
        if (op != 4'hF) m_trap = 1'b1;
        hn = (k == 3) ? 1 : $urandom_range(1, 3);
        for (int h = 0; h < hn; h++) begin
          c = base(); c.busy = 1'b0; c.halted = 1'b1; c.start = (h == hn - 1);
          tr.push_back(c);
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (run) begin
      e = tr[cur];
      chk("mem_req",   16'(mem_req),   16'(e.req));
      chk("mem_we",    16'(mem_we),    16'(e.we));
      chk("rf_we",     16'(rf_we),     16'(e.rfwe));
      chk("busy",      16'(busy),      16'(e.busy));
      chk("halted",    16'(halted),    16'(e.halted));
      chk("trap",      16'(trap),      16'(e.trap));
      chk("pc",        16'(pc),        16'(e.pc));
      chk("op_code",   16'(op_code),   16'(e.ir[15:12]));
      chk("rf_waddr",  16'(rf_waddr),  16'(e.ir[11:8]));
      chk("rf_raddr1", 16'(rf_raddr1), 16'(e.ir[7:4]));
      chk("rf_raddr2", 16'(rf_raddr2), 16'(e.ir[3:0]));
      if (e.req)         chk("mem_addr",  16'(mem_addr), 16'(e.addr));
      if (e.req && e.we) chk("mem_wdata", mem_wdata, e.wdata);
      if (e.rfwe)        chk("rf_wdata",  rf_wdata, e.rfwdata);
      case (cur)
        2:  begin chk("lit_op", 16'(op_code), 16'h0); chk("lit_ra1", 16'(rf_raddr1), 16'h2);
                  chk("lit_ra2", 16'(rf_raddr2), 16'h3); end
        4:  begin chk("lit_wb_we", 16'(rf_we), 16'h1); chk("lit_wb_addr", 16'(rf_waddr), 16'h1);
                  chk("lit_pc1", 16'(pc), 16'h1); end
        9:  begin chk("lit_ld_req", 16'(mem_req), 16'h1); chk("lit_ld_addr", 16'(mem_addr), 16'h40); end
        12: begin chk("lit_ld_wd", rf_wdata, 16'hBEEF); chk("lit_ld_wa", 16'(rf_waddr), 16'h2); end
        16: begin chk("lit_st_we", 16'(mem_we), 16'h1); chk("lit_st_wd", mem_wdata, 16'h0040); end
        19: begin chk("lit_halted", 16'(halted), 16'h1); chk("lit_hbusy", 16'(busy), 16'h0);
                  chk("lit_hpc", 16'(pc), 16'h4); end
        20: chk("lit_resume", 16'(mem_addr), 16'h4);
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
        22: begin chk("lit_trap", 16'(trap), 16'h1); chk("lit_thalt", 16'(halted), 16'h1); end
`else
        22: begin chk("lit_nop_req", 16'(mem_req), 16'h1); chk("lit_nop_pc", 16'(mem_addr), 16'h5); end
`endif
        default: ;
      endcase
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog t=%0t got=timeout want=finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    logic [3:0] op;
    for (int i = 0; i < 16; i++) regs[i] = 16'($urandom);
    regs[4] = 16'h0040;
    for (int a = 0; a < 256; a++) begin
      r  = $urandom_range(0, 19);
      op = (r < 10) ? 4'(r % 5) : (r < 13) ? 4'h5 : (r < 16) ? 4'h6 :
           (r == 16) ? 4'hF : 4'($urandom_range(7, 14));
      pmem[a] = {op, 12'($urandom)};
    end
    pmem[0] = 16'h0123; pmem[1] = 16'h5204; pmem[2] = 16'h6104;
    pmem[3] = 16'hF000; pmem[4] = 16'h9000;
    gen();

    repeat (2) @(negedge clk);
    chk("rst_mem_req",  16'(mem_req),  16'h0);
    chk("rst_mem_we",   16'(mem_we),   16'h0);
    chk("rst_rf_we",    16'(rf_we),    16'h0);
    chk("rst_busy",     16'(busy),     16'h0);
    chk("rst_halted",   16'(halted),   16'h0);
    chk("rst_trap",     16'(trap),     16'h0);
    chk("rst_pc",       16'(pc),       16'h0);
    chk("rst_mem_addr", 16'(mem_addr), 16'h0);
    chk("rst_wdata",    mem_wdata,     16'h0);
    chk("rst_rfwdata",  rf_wdata,      16'h0);
    chk("rst_op",       16'(op_code),  16'h0);
    rst_n = 1'b1;

    for (int i = 0; i < tr.size(); i++) begin
      @(posedge clk); #1;
      start = tr[i].start; mem_ack = tr[i].ack; mem_rdata = tr[i].rdata; alu_res = tr[i].alu;
      cur = i; run = 1'b1;
    end
    @(posedge clk); #1;
    run = 1'b0; cur = -1; start = 1'b0; mem_ack = 1'b0;
    // DUT is still waiting on the final LOAD's data ack here.
    chk("mid_req_before", 16'(mem_req), 16'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_req",  16'(mem_req), 16'h0);
    chk("mid_rst_busy", 16'(busy),    16'h0);
    chk("mid_rst_pc",   16'(pc),      16'h0);
    chk("mid_rst_rfwe", 16'(rf_we),   16'h0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_rfwe", 16'(rf_we),    16'h0);
    chk("post_rst_req",  16'(mem_req),  16'h0);
    chk("post_rst_wd",   rf_wdata,      16'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
